// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial ALU blocks: controller states and default width.
package serial_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_e;

endpackage

// File: rtl/bit_serial_adder16_fa.sv
// Single-bit full-adder slice; the only arithmetic in the bit-serial adder.
module bit_serial_adder16_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/bit_serial_adder16.sv
// LSB-first bit-serial adder: one full-adder slice plus a carry flop, valid/ready on both sides.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVERFLOW_EN.
module bit_serial_adder16
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_c;

  bit_serial_adder16_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Accept edge only loads operands; the result register keeps the previous sum.
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          // On the MSB, carry_q is the carry into the sign bit.
          ovf_d   = carry_q ^ fa_c;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder16.sv
// Bench for bit_serial_adder16: directed transactions plus a cycle-level reference model.
module tb_bit_serial_adder16;

  localparam int W = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: phase of the transaction and result last produced.
  int           m_phase = M_IDLE;
  int           m_left  = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;

  bit_serial_adder16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    logic [W:0] t;
    if (!rst_n) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
      m_phase = M_IDLE;
      m_left  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_phase == M_IDLE});
      chk("m_busy", {31'd0, busy}, {31'd0, m_phase == M_RUN});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_phase == M_DONE});
      if (m_phase != M_RUN) begin
        chk("m_sum", {16'd0, sum}, {16'd0, m_sum});
        chk("m_cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
`endif
      end
      case (m_phase)
        M_IDLE: if (in_valid) begin
          t       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          m_sum   = t[W-1:0];
          m_cout  = t[W];
          m_ovf   = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
          m_left  = W;
          m_phase = M_RUN;
        end
        M_RUN: begin
          m_left--;
          if (m_left == 0) m_phase = M_DONE;
        end
        default: if (out_ready) m_phase = M_IDLE;
      endcase
    end
  end

  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tc,
                        input logic [W-1:0] exp_s, input logic exp_c, input logic exp_o,
                        input int hold, input bit noisy);
    int k;
    logic [W-1:0] s0;
    logic         c0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_b; cin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    k = 0;
    while (!out_valid && k < 40) begin
      if (noisy) begin
        in_valid = k[0];
        a = W'($urandom);
        b = W'($urandom);
        cin = ~cin;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_vec++; n_fail++;
      $display("FAIL done_timeout: out_valid still 0 after %0d cycles", k);
    end
    chk("latency", k, W);
    chk("lit_sum", {16'd0, sum}, {16'd0, exp_s});
    chk("lit_cout", {31'd0, cout}, {31'd0, exp_c});
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("lit_ovf", {31'd0, overflow}, {31'd0, exp_o});
`else
    if (exp_o) k = k;
`endif
    s0 = sum; c0 = cout;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_sum", {16'd0, sum}, {16'd0, s0});
      chk("hold_cout", {31'd0, cout}, {31'd0, c0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);
    chk("init_sum", {16'd0, sum}, 32'd0);
    #2 rst_n = 1'b1;

    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_add(16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
    do_add(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 5, 1'b0);
    do_add(16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 1'b0);
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);

    // Abort mid-RUN: outputs must return to reset values without waiting for a clock.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    do_add(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
